// File: rtl/adc_emu_pkg.sv
// rtl/adc_emu_pkg.sv - shared defaults, frame length helper and state type for the ADC serial emulator
package adc_emu_pkg;

   localparam int W_DATA_DEF = 18;
   localparam int N_CHAN_DEF = 8;

   // Bits carried per serial line in one frame; half the channels ride each line.
   function automatic int tx_len(input int w_data, input int n_chan);
      return (w_data * n_chan) / 2;
   endfunction

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CONV  = 2'd1,
      READY = 2'd2,
      SHIFT = 2'd3
   } state_t;

endpackage

// File: rtl/sync_edge_det.sv
// rtl/sync_edge_det.sv - two-flop synchronizer with registered edge detector (level/rise/fall)
module sync_edge_det (
   input  logic clk,
   input  logic rst,
   input  logic din,
   output logic level,
   output logic rise,
   output logic fall
);

   logic s1;
   logic s2;
   logic prev;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1   <= 1'b0;
         s2   <= 1'b0;
         prev <= 1'b0;
      end else begin
         s1   <= din;
         s2   <= s1;
         prev <= s2;
      end
   end

   // Edges are decoded off the second stage so they cost no extra cycle.
   assign level = s2;
   assign rise  = s2 & ~prev;
   assign fall  = ~s2 & prev;

endmodule

// File: rtl/adc_serial_emulator.sv
// rtl/adc_serial_emulator.sv - ADC-side convst/busy/n_cs/sclk responder; ADC_EMU_RAMP_EN replaces channel data with a ramp
module adc_serial_emulator
   import adc_emu_pkg::*;
#(
   parameter int W_DATA   = W_DATA_DEF,
   parameter int N_CHAN   = N_CHAN_DEF,
   parameter int BUSY_CYC = 200
) (
   input  logic                       clk50_in,
   input  logic                       rst_in,
   input  logic [W_DATA*N_CHAN-1:0]   chan_data_in,
   input  logic                       convst_in,
   input  logic                       n_cs_in,
   input  logic                       sclk_in,
   output logic                       busy_out,
   output logic                       data_a_out,
   output logic                       data_b_out,
   output logic                       frame_done_out
);

   localparam int TX_LEN = tx_len(W_DATA, N_CHAN);
   localparam int CW     = $clog2(TX_LEN + 1);
   localparam int BW     = (BUSY_CYC > 1) ? $clog2(BUSY_CYC) : 1;

   logic [2:0] lvl_unused;
   logic       convst_rise;
   logic       convst_fall_unused;
   logic       n_cs_rise;
   logic       n_cs_fall;
   logic       sclk_rise_unused;
   logic       sclk_fall;

   sync_edge_det u_sync_convst (
      .clk (clk50_in), .rst (rst_in), .din (convst_in),
      .level (lvl_unused[0]), .rise (convst_rise), .fall (convst_fall_unused)
   );

   sync_edge_det u_sync_n_cs (
      .clk (clk50_in), .rst (rst_in), .din (n_cs_in),
      .level (lvl_unused[1]), .rise (n_cs_rise), .fall (n_cs_fall)
   );

   sync_edge_det u_sync_sclk (
      .clk (clk50_in), .rst (rst_in), .din (sclk_in),
      .level (lvl_unused[2]), .rise (sclk_rise_unused), .fall (sclk_fall)
   );

   state_t                    state;
   state_t                    state_nxt;
   logic                      start;
   logic                      conv_active;
   logic [BW-1:0]             busy_cnt;
   logic [CW-1:0]             bit_cnt;
   logic [TX_LEN-1:0]         sh_a;
   logic [TX_LEN-1:0]         sh_b;
   logic [W_DATA*N_CHAN-1:0]  snap;

`ifdef ADC_EMU_RAMP_EN
   logic signed [W_DATA-1:0] ramp;
   logic                     unused_chan;

   assign unused_chan = ^chan_data_in;

   // Two's complement overflow gives the max-to-min wrap for free.
   always_ff @(posedge clk50_in or posedge rst_in) begin
      if (rst_in) begin
         ramp <= '0;
      end else if (frame_done_out) begin
         ramp <= ramp + W_DATA'(1);
      end
   end

   always_comb begin
      snap = '0;
      for (int i = 0; i < N_CHAN; i++) begin
         snap[W_DATA*(N_CHAN-i)-1 -: W_DATA] = ramp + W_DATA'(i);
      end
   end
`else
   assign snap = chan_data_in;
`endif

   always_comb begin
      state_nxt      = state;
      start          = 1'b0;
      frame_done_out = 1'b0;
      case (state)
         IDLE: begin
            if (convst_rise) begin
               start     = 1'b1;
               state_nxt = CONV;
            end
         end
         CONV: begin
            if (n_cs_fall) begin
               state_nxt = SHIFT;
            end else if (busy_cnt == '0) begin
               state_nxt = READY;
            end
         end
         READY: begin
            if (n_cs_fall) begin
               state_nxt = SHIFT;
            end else if (convst_rise) begin
               start     = 1'b1;
               state_nxt = CONV;
            end
         end
         SHIFT: begin
            if (bit_cnt == CW'(TX_LEN)) begin
               frame_done_out = 1'b1;
               state_nxt      = IDLE;
            end else if (n_cs_rise) begin
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk50_in or posedge rst_in) begin
      if (rst_in) begin
         state       <= IDLE;
         conv_active <= 1'b0;
         busy_cnt    <= '0;
         bit_cnt     <= '0;
         sh_a        <= '0;
         sh_b        <= '0;
      end else begin
         state <= state_nxt;
         if (start) begin
            sh_a        <= snap[W_DATA*N_CHAN-1 -: TX_LEN];
            sh_b        <= snap[TX_LEN-1:0];
            busy_cnt    <= BW'(BUSY_CYC - 1);
            conv_active <= 1'b1;
         end else begin
            // Busy keeps counting through an early readout; only its own count ends it.
            if (conv_active) begin
               if (busy_cnt == '0) begin
                  conv_active <= 1'b0;
               end else begin
                  busy_cnt <= busy_cnt - BW'(1);
               end
            end
            if (state_nxt == IDLE) begin
               conv_active <= 1'b0;
            end
         end
         if (state != SHIFT) begin
            bit_cnt <= '0;
         end else if (sclk_fall && (bit_cnt != CW'(TX_LEN))) begin
            sh_a    <= {sh_a[TX_LEN-2:0], 1'b0};
            sh_b    <= {sh_b[TX_LEN-2:0], 1'b0};
            bit_cnt <= bit_cnt + CW'(1);
         end
      end
   end

   assign busy_out   = conv_active;
   assign data_a_out = (state == SHIFT) & sh_a[TX_LEN-1];
   assign data_b_out = (state == SHIFT) & sh_b[TX_LEN-1];

endmodule

// File: doc/adc_serial_emulator.md
# adc_serial_emulator

Synthesizable responder for the ADC serial readout interface: it plays the ADC side of the convst/busy/n_cs/sclk handshake that the PID controller's ADC front end initiates. It accepts a conversion start, asserts busy for a programmable time, and then shifts eight signed 18-bit channel words out on two serial lines, MSB first. It sits outside `pid_controller` on the loopback/self-test board build and in bench environments, wired pin-for-pin to `adc_convst_out`, `adc_n_cs_out`, `adc_sclk_out`, `adc_busy_in`, `adc_data_a_in` and `adc_data_b_in`.

## Interface
- W_DATA, 18, bits per channel word
- N_CHAN, 8, channels; must be even; half go on each line
- BUSY_CYC, 200, clk50_in cycles that busy is held high after a convst rising edge; minimum 1
- clk50_in  in  1  system clock, at least 4× the sclk_in frequency
- rst_in  in  1  asynchronous, active-high reset
- chan_data_in  in  W_DATA*N_CHAN  channel words; channel i occupies bits [W_DATA*(N_CHAN-i)-1 -: W_DATA], so channel 0 is in the MSBs
- convst_in  in  1  conversion start, asynchronous to clk50_in
- n_cs_in  in  1  active-low chip select, asynchronous
- sclk_in  in  1  serial clock, asynchronous; data changes on its falling edge
- busy_out  out  1  conversion in progress
- data_a_out  out  1  serial data carrying channels 0 to N_CHAN/2-1
- data_b_out  out  1  serial data carrying channels N_CHAN/2 to N_CHAN-1
- frame_done_out  out  1  one-cycle pulse when TX_LEN = W_DATA*N_CHAN/2 bits have been shifted

## Operation
- Input sync: convst_in, n_cs_in and sclk_in each pass through a 2-flop synchronizer, then an edge detector (registered previous value).
- FSM states: IDLE, CONV, READY, SHIFT.
- IDLE: busy_out=0. On a convst rising edge:
  - snapshot chan_data_in into shadow registers sh_a and sh_b (TX_LEN bits each);
  - load the busy counter with BUSY_CYC-1;
  - go to CONV.
- CONV: busy_out=1; the counter decrements each cycle. At 0, go to READY.
  - An n_cs falling edge in CONV is also accepted: go to SHIFT and keep busy_out=1 until the counter expires. Early readout returns the new snapshot.
- READY: busy_out=0. An n_cs falling edge enters SHIFT. A convst rising edge restarts the conversion (new snapshot, back to CONV).
- SHIFT:
  - data_a_out = sh_a[TX_LEN-1] and data_b_out = sh_b[TX_LEN-1] continuously.
  - On each sclk falling edge, both shift registers shift left by one, filling 0, and the bit counter increments.
  - When the counter reaches TX_LEN: frame_done_out pulses, then go to IDLE.
  - An n_cs rising edge before TX_LEN aborts to IDLE with no frame_done.
- convst edges are ignored in CONV and SHIFT.
- Outside SHIFT, data_a_out and data_b_out are 0.
- The bit counter is 7 bits wide for the defaults; it is sized as $clog2(TX_LEN+1).

## Timing
- Reset values: busy_out=0, data_a_out=0, data_b_out=0, frame_done_out=0, state=IDLE, shift registers and counters 0.
- Latency from the convst_in pin rise to busy_out=1 is 3 clk50_in cycles: 2 synchronizer stages plus the state register.
- busy_out stays high for exactly BUSY_CYC cycles, unless an early SHIFT extends nothing. The counter alone governs busy_out.
- The first data bit (MSB of channel 0 or channel 4) appears 3 cycles after the n_cs_in pin falls. Each later bit appears 3 cycles after an sclk_in pin fall.
- frame_done_out asserts in the cycle after the TX_LEN-th sclk falling edge is detected.
- A reset asserted mid-frame returns all outputs to their reset values immediately. The shadow data is discarded.
- sclk edges outside SHIFT are ignored.

## Configuration
- ADC_EMU_RAMP_EN:
  - Defined: chan_data_in is ignored. Each snapshot loads channel i with ramp+i, where ramp is an internal signed W_DATA-bit counter. ramp resets to 0, increments by 1 after every completed frame, and wraps at 2^(W_DATA-1)-1 to -2^(W_DATA-1).
  - Undefined: chan_data_in is used and no ramp logic exists.

## Structure
- Shared package `adc_emu_pkg`:
  - W_DATA and N_CHAN defaults;
  - the TX_LEN function;
  - the state enum type (IDLE, CONV, READY, SHIFT).
- Sub-module `sync_edge_det`:
  - 2-flop synchronizer plus registered edge detector;
  - outputs: level, rise, fall;
  - instantiated three times.

## Test plan
- Reset, channel words 2222,0,0,0,0,0,0,0, convst pulse, BUSY_CYC=200 → busy high for 200 cycles. After n_cs low and 72 sclk falls, data_a reconstructs to {2222,0,0,0} and frame_done pulses once.
- Channels 1111,-2,3333,-4,5555,-6,7777,-8 → line A = {1111,-2,3333,-4}, line B = {5555,-6,7777,-8}, two's complement, MSB first.
- n_cs low while busy is high, 40 cycles after convst → busy still drops at cycle 200. All 72 bits are correct and come from the new snapshot.
- n_cs rises after 30 bits → state IDLE, no frame_done, data lines 0. The next convst produces a complete correct frame.
- rst_in pulsed mid-SHIFT → all outputs 0 within the reset assertion. Later sclk edges produce no output until the next convst/n_cs sequence.
- With ADC_EMU_RAMP_EN, three consecutive frames → channel 0 reads 0, 1, 2 and channel 7 reads 7, 8, 9.
